// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: scans masked mux channels through one shared ADC, averaging 2^AVG_BITS samples per result.
// Optional ADC_SCAN_TIMEOUT_EN adds a sample watchdog and the timeout_err output.
module adc_scan_sequencer #(
   parameter int NUM_CH         = 4,
   parameter int CH_BITS        = 2,
   parameter int ADC_WIDTH      = 8,
   parameter int SETTLE_SAMPLES = 2,
   parameter int AVG_BITS       = 2,
   parameter int RST_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [NUM_CH-1:0]    ch_mask,
   input  logic                 adc_sample_rdy,
   input  logic [ADC_WIDTH-1:0] adc_data,
   output logic                 adc_rstn,
   output logic [CH_BITS-1:0]   mux_sel,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ADC_WIDTH-1:0] res_data,
   output logic [CH_BITS-1:0]   res_ch,
   output logic                 busy,
   output logic                 scan_done
`ifdef ADC_SCAN_TIMEOUT_EN
   ,
   output logic                 timeout_err
`endif
);
   localparam int AW   = ADC_WIDTH + AVG_BITS;
   localparam int NAVG = 1 << AVG_BITS;
   typedef enum logic [2:0] {IDLE, SWITCH, SETTLE, ACCUM, OUTPUT} state_t;
   state_t state;
   logic [CH_BITS-1:0] cur_ch, lo_ch, hi_ch, nxt_ch;
   logic hi_ok, hs;
   logic [15:0] cnt;
   logic [AW-1:0] acc;
`ifdef ADC_SCAN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
`endif
   assign hs       = res_valid & res_ready;
   assign adc_rstn = !(state == IDLE || state == SWITCH);
   assign busy     = state != IDLE;
   assign nxt_ch   = hi_ok ? hi_ch : lo_ch;
   // lo_ch: lowest enabled channel; hi_ch: lowest enabled channel above cur_ch
   always_comb begin
      lo_ch = '0;
      hi_ch = '0;
      hi_ok = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) lo_ch = CH_BITS'(i);
         if (ch_mask[i] && i > int'(cur_ch)) begin
            hi_ch = CH_BITS'(i);
            hi_ok = 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_ch    <= '0;
         mux_sel   <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_ch    <= '0;
         scan_done <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
`ifdef ADC_SCAN_TIMEOUT_EN
         timeout_err <= 1'b0;
         tcnt        <= '0;
`endif
      end else begin
         scan_done <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
         timeout_err <= 1'b0;
         tcnt <= (adc_sample_rdy || !(state == SETTLE || state == ACCUM)) ? '0 : tcnt + 1'b1;
`endif
         case (state)
            IDLE: if (run && ch_mask != '0) begin
               cur_ch  <= lo_ch;
               mux_sel <= lo_ch;
               cnt     <= '0;
               state   <= SWITCH;
            end
            SWITCH: if (cnt == 16'(RST_CYCLES - 1)) begin
               cnt   <= '0;
               acc   <= '0;
               state <= (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
            end else cnt <= cnt + 1'b1;
            SETTLE: if (adc_sample_rdy) begin
               if (cnt == 16'(SETTLE_SAMPLES - 1)) begin
                  cnt   <= '0;
                  acc   <= '0;
                  state <= ACCUM;
               end else cnt <= cnt + 1'b1;
            end
`ifdef ADC_SCAN_TIMEOUT_EN
            else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
               timeout_err <= 1'b1;
               res_data    <= '1;
               res_ch      <= cur_ch;
               res_valid   <= 1'b1;
               state       <= OUTPUT;
            end
`endif
            ACCUM: if (adc_sample_rdy) begin
               if (cnt == 16'(NAVG - 1)) begin
                  res_data  <= ADC_WIDTH'((acc + AW'(adc_data)) >> AVG_BITS);
                  res_ch    <= cur_ch;
                  res_valid <= 1'b1;
                  state     <= OUTPUT;
               end else begin
                  acc <= acc + AW'(adc_data);
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef ADC_SCAN_TIMEOUT_EN
            else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
               timeout_err <= 1'b1;
               res_data    <= '1;
               res_ch      <= cur_ch;
               res_valid   <= 1'b1;
               state       <= OUTPUT;
            end
`endif
            OUTPUT: if (hs) begin
               res_valid <= 1'b0;
               scan_done <= !hi_ok;
               cnt       <= '0;
               acc       <= '0;
               cur_ch    <= nxt_ch;
               // same channel again: ADC already settled on it, so skip switch and settle
               if (!run || ch_mask == '0) state <= IDLE;
               else if (nxt_ch != cur_ch) begin
                  mux_sel <= nxt_ch;
                  state   <= SWITCH;
               end else state <= ACCUM;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: randomized ADC stub plus spec-level scan/average model for adc_scan_sequencer.
module tb_adc_scan_sequencer;
   logic clk = 0, rst = 1, run = 0, res_ready = 0;
   logic [3:0] ch_mask = 0;
   logic adc_sample_rdy, adc_rstn, res_valid, busy, scan_done;
   logic [7:0] adc_data, res_data;
   logic [1:0] mux_sel, res_ch;
`ifdef ADC_SCAN_TIMEOUT_EN
   logic timeout_err;
`endif
   int n_cmp = 0, n_bad = 0;
   int exp_ch = 0, exp_sd = 0, sd_cnt = 0, mux_bad = 0, lrun = 0, gap = 0;
   bit dmode = 1;
   logic [7:0] chan_val [4] = '{8'd10, 8'd20, 8'd30, 8'd40};
   logic [7:0] script[$];
   logic [7:0] smp[$];
   int lowlen[$];
   logic [1:0] pmux;
   logic prstn, pbusy;

   adc_scan_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .ch_mask(ch_mask),
      .adc_sample_rdy(adc_sample_rdy), .adc_data(adc_data), .adc_rstn(adc_rstn),
      .mux_sel(mux_sel), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ch(res_ch), .busy(busy), .scan_done(scan_done)
`ifdef ADC_SCAN_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   // ADC stub: pulses only while out of reset, data from script, per-channel constant or random
   initial begin
      adc_sample_rdy = 0;
      adc_data = 0;
      forever begin
         @(posedge clk);
         #1;
         adc_sample_rdy = 0;
         if (gap > 0) gap--;
         else if (adc_rstn === 1'b1) begin
            adc_sample_rdy = 1;
            adc_data = script.size() > 0 ? script.pop_front() : (dmode ? chan_val[mux_sel] : 8'($urandom));
            gap = $urandom_range(2, 5);
         end
      end
   end

   // observe samples since the ADC left reset, reset-low run lengths, mux changes, scan_done pulses
   always @(negedge clk) begin
      if (adc_rstn === 1'b0) smp.delete();
      else if (adc_sample_rdy) smp.push_back(adc_data);
      if (adc_rstn === 1'b0 && busy === 1'b1) lrun++;
      else begin
         if (lrun > 0) lowlen.push_back(lrun);
         lrun = 0;
      end
      if (mux_sel != pmux && !(adc_rstn === 1'b0 && (prstn === 1'b1 || pbusy === 1'b0))) mux_bad++;
      if (scan_done === 1'b1) sd_cnt++;
      pmux = mux_sel;
      prstn = adc_rstn;
      pbusy = busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int next_above(input int c, input logic [3:0] m);
      for (int i = c + 1; i < 4; i++) if (m[i]) return i;
      return -1;
   endfunction

   function automatic int lowest(input logic [3:0] m);
      for (int i = 0; i < 4; i++) if (m[i]) return i;
      return -1;
   endfunction

   task automatic res_step(input int hold, output logic [7:0] d);
      int t, bad, nx, s;
      logic [7:0] hd;
      logic [1:0] hc;
      d = 'x;
      if (hold > 0) res_ready = 0;
      t = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("res_arrive", res_valid, 1);
      if (res_valid !== 1'b1) return;
      d = res_data;
      if (smp.size() < 6) chk("sample_count", smp.size(), 6);
      else begin
         s = int'(smp[2]) + int'(smp[3]) + int'(smp[4]) + int'(smp[5]);
         chk("res_data", res_data, s / 4);
      end
      chk("res_ch", res_ch, exp_ch);
      chk("scan_done_cnt", sd_cnt, exp_sd);
      hd = res_data;
      hc = res_ch;
      bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== hd || res_ch !== hc || mux_sel !== hc || adc_rstn !== 1'b1) bad++;
      end
      if (hold > 0) chk("backpressure_hold", bad, 0);
      res_ready = 1;
      @(posedge clk);
      #1;
      chk("valid_drop", res_valid, 0);
      nx = next_above(exp_ch, ch_mask);
      chk("scan_done", scan_done, nx < 0);
      if (nx < 0) begin
         exp_sd++;
         nx = lowest(ch_mask);
      end
      if (!run || ch_mask == 0) begin
         chk("idle_busy", busy, 0);
         chk("idle_rstn", adc_rstn, 0);
         exp_ch = -1;
      end else begin
         chk("next_mux", mux_sel, nx);
         chk("switch_rstn", adc_rstn, 0);
         exp_ch = nx;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      int t, cnt;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", res_valid, 0);
      chk("rst_rstn", adc_rstn, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mux", mux_sel, 0);
      chk("rst_data", res_data, 0);
      chk("rst_ch", res_ch, 0);
      chk("rst_done", scan_done, 0);
      rst = 0;
      // full scan with constant per-channel data
      ch_mask = 4'b1111;
      run = 1;
      res_ready = 1;
      exp_ch = 0;
      for (int k = 0; k < 5; k++) begin
         res_step(0, d);
         chk("const_data", d, chan_val[k % 4]);
      end
      // sparse mask with random data: channels 1,3,1,3
      ch_mask = 4'b1010;
      dmode = 0;
      for (int k = 0; k < 4; k++) res_step(0, d);
      // truncating average; the two settle samples are excluded
      script = '{8'd255, 8'd255, 8'd3, 8'd4, 8'd4, 8'd4};
      res_step(0, d);
      chk("trunc_avg", d, 3);
      // 50 cycles of backpressure on channel 3
      res_step(50, d);
      // run drops during channel 1 accumulation
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (smp.size() < 3 && t < 2000);
      chk("accum_reached", smp.size() >= 3, 1);
      run = 0;
      res_step(0, d);
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0 || adc_rstn !== 1'b0) cnt++;
      end
      chk("idle_quiet", cnt, 0);
      // reset while a channel 2 result is pending
      ch_mask = 4'b1100;
      res_ready = 0;
      run = 1;
      t = 0;
      while (res_valid !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("pending_valid", res_valid, 1);
      chk("pending_mux", mux_sel, 2);
      rst = 1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", res_valid, 0);
      chk("mid_rst_rstn", adc_rstn, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mux", mux_sel, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      res_ready = 1;
      exp_ch = lowest(ch_mask);
      res_step(0, d);
      cnt = 0;
      foreach (lowlen[i]) if (lowlen[i] != 4) cnt++;
      chk("rstn_low_len", cnt, 0);
      chk("rstn_low_seen", lowlen.size() >= 10, 1);
      chk("mux_only_on_switch", mux_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
